sq_dur_mon_multi: RTL and testbench

//  Parametrised multi-slot store-queue residency monitor for AVF/cross-layer profiling.

---
 rtl/sq_dur_mon_multi_if.sv | 42 ++++
 rtl/sq_dur_mon_multi.sv | 224 ++++++++++++++++++++++
 tb/tb_sq_dur_mon_multi.sv | 383 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sq_dur_mon_multi_if.sv
// Event and result bundle between a store-queue event source and the
// multi-slot residency monitor.
interface sq_dur_mon_multi_if #(
  parameter int IDX_W   = 6,
  parameter int TS_W    = 10,
  parameter int CNT_W   = 8,
  parameter int NUM_MON = 4,
  parameter int DROP_W  = 16
);
  logic [CNT_W-1:0]   counter_in;
  logic [TS_W-1:0]    timestamp;
  logic               alloc_valid;
  logic [IDX_W-1:0]   alloc_idx;
  logic               exec_valid;
  logic [IDX_W-1:0]   exec_idx;
  logic               retire_valid;
  logic [IDX_W-1:0]   retire_idx;
  logic               flush;

  logic               res_valid;
  logic [3:0]         res_slot;
  logic [TS_W-1:0]    res_dur_exec;
  logic [TS_W-1:0]    res_dur_end;
  logic               res_exec_seen;
  logic               res_timeout;
  logic [NUM_MON-1:0] busy_mask;
  logic [DROP_W-1:0]  drop_cnt;

  modport master (
    output counter_in, timestamp, alloc_valid, alloc_idx, exec_valid, exec_idx,
           retire_valid, retire_idx, flush,
    input  res_valid, res_slot, res_dur_exec, res_dur_end, res_exec_seen,
           res_timeout, busy_mask, drop_cnt
  );

  modport slave (
    input  counter_in, timestamp, alloc_valid, alloc_idx, exec_valid, exec_idx,
           retire_valid, retire_idx, flush,
    output res_valid, res_slot, res_dur_exec, res_dur_end, res_exec_seen,
           res_timeout, busy_mask, drop_cnt
  );
endinterface

// File: rtl/sq_dur_mon_multi.sv
// Multi-slot store-queue residency monitor: samples entries at allocation and
// times them to execute and to retire, with per-slot timeout reclaim.
module sq_dur_mon_multi #(
  parameter int IDX_W   = 6,
  parameter int TS_W    = 10,
  parameter int CNT_W   = 8,
  parameter int NUM_MON = 4,
  parameter int TIMEOUT = 1023,
  parameter int DROP_W  = 16
) (
  input logic               clk,
  input logic               reset,
  sq_dur_mon_multi_if.slave bus
);

  localparam int AGE_W = $clog2(TIMEOUT + 1);
  localparam logic [AGE_W-1:0] AGE_LAST = AGE_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_FREE,
    S_ARMED,
    S_EXECD,
    S_TOPEND
  } slot_state_e;

  slot_state_e       state_q [NUM_MON];
  slot_state_e       state_d [NUM_MON];
  logic [IDX_W-1:0]  idx_q   [NUM_MON];
  logic [IDX_W-1:0]  idx_d   [NUM_MON];
  logic [TS_W-1:0]   start_q [NUM_MON];
  logic [TS_W-1:0]   start_d [NUM_MON];
  logic [TS_W-1:0]   dexec_q [NUM_MON];
  logic [TS_W-1:0]   dexec_d [NUM_MON];
  logic [TS_W-1:0]   dend_q  [NUM_MON];
  logic [TS_W-1:0]   dend_d  [NUM_MON];
  logic [AGE_W-1:0]  age_q   [NUM_MON];
  logic [AGE_W-1:0]  age_d   [NUM_MON];
  logic [TS_W-1:0]   elapsed [NUM_MON];
  logic [NUM_MON-1:0] seen_q;
  logic [NUM_MON-1:0] seen_d;

  logic [NUM_MON-1:0] busy;
  logic [NUM_MON-1:0] ret_hit;
  logic [NUM_MON-1:0] exe_hit;
  logic [NUM_MON-1:0] dup_hit;
  logic [NUM_MON-1:0] arm_sel;
  logic [NUM_MON-1:0] to_sel;
  logic               free_found;
  logic               to_found;
  logic               arm_req;
  logic               drop;
  logic               ret_any;

  logic               res_fire;
  logic [3:0]         res_slot_d;
  logic [TS_W-1:0]    res_dexec_d;
  logic [TS_W-1:0]    res_dend_d;
  logic               res_seen_d;
  logic               res_to_d;

  logic               res_valid_q;
  logic [3:0]         res_slot_q;
  logic [TS_W-1:0]    res_dexec_q;
  logic [TS_W-1:0]    res_dend_q;
  logic               res_seen_q;
  logic               res_to_q;
  logic [DROP_W-1:0]  drop_q;

  // Per-slot matches against this cycle's events, all from registered state.
  always_comb begin
    busy    = '0;
    ret_hit = '0;
    exe_hit = '0;
    dup_hit = '0;
    for (int i = 0; i < NUM_MON; i++) begin
      busy[i]    = (state_q[i] != S_FREE);
      ret_hit[i] = bus.retire_valid && busy[i] && (idx_q[i] == bus.retire_idx);
      exe_hit[i] = bus.exec_valid && busy[i] && !seen_q[i] && (idx_q[i] == bus.exec_idx);
      dup_hit[i] = busy[i] && !ret_hit[i] && (idx_q[i] == bus.alloc_idx);
      elapsed[i] = bus.timestamp - start_q[i];
    end
  end

  always_comb begin
    arm_sel    = '0;
    to_sel     = '0;
    free_found = 1'b0;
    to_found   = 1'b0;
    for (int i = 0; i < NUM_MON; i++) begin
      if (!free_found && state_q[i] == S_FREE) begin
        arm_sel[i] = 1'b1;
        free_found = 1'b1;
      end
      if (!to_found && state_q[i] == S_TOPEND) begin
        to_sel[i] = 1'b1;
        to_found  = 1'b1;
      end
    end
    arm_req = bus.alloc_valid && (bus.counter_in == '0) && !bus.flush;
    drop    = arm_req && ((|dup_hit) || !free_found);
    if (!arm_req || (|dup_hit)) begin
      arm_sel = '0;
    end
    ret_any = |ret_hit;
    // A retire completion owns the result port; flush suppresses timeouts.
    if (ret_any || bus.flush) begin
      to_sel = '0;
    end
  end

  always_comb begin
    res_fire    = ret_any || (|to_sel);
    res_slot_d  = '0;
    res_dexec_d = '0;
    res_dend_d  = '0;
    res_seen_d  = 1'b0;
    res_to_d    = 1'b0;
    for (int i = 0; i < NUM_MON; i++) begin
      if (ret_hit[i]) begin
        res_slot_d  = 4'(i);
        res_dend_d  = elapsed[i];
        res_seen_d  = seen_q[i] || exe_hit[i];
        res_dexec_d = seen_q[i] ? dexec_q[i] : elapsed[i];
      end else if (to_sel[i]) begin
        res_slot_d  = 4'(i);
        res_dend_d  = dend_q[i];
        res_seen_d  = seen_q[i];
        res_dexec_d = seen_q[i] ? dexec_q[i] : dend_q[i];
        res_to_d    = 1'b1;
      end
    end
  end

  // Slot lifecycle: completion and flush free a slot; arming only lands on a
  // slot that was already free at the start of the cycle.
  always_comb begin
    for (int i = 0; i < NUM_MON; i++) begin
      state_d[i] = state_q[i];
      idx_d[i]   = idx_q[i];
      start_d[i] = start_q[i];
      dexec_d[i] = dexec_q[i];
      dend_d[i]  = dend_q[i];
      age_d[i]   = age_q[i];
      seen_d[i]  = seen_q[i];
      if (ret_hit[i] || to_sel[i] || bus.flush) begin
        state_d[i] = S_FREE;
      end else begin
        if (exe_hit[i]) begin
          seen_d[i]  = 1'b1;
          dexec_d[i] = elapsed[i];
          if (state_q[i] == S_ARMED) begin
            state_d[i] = S_EXECD;
          end
        end
        if (state_q[i] == S_ARMED || state_q[i] == S_EXECD) begin
          age_d[i] = age_q[i] + 1'b1;
          if (age_q[i] == AGE_LAST) begin
            state_d[i] = S_TOPEND;
            dend_d[i]  = elapsed[i];
          end
        end
      end
      if (arm_sel[i]) begin
        state_d[i] = S_ARMED;
        idx_d[i]   = bus.alloc_idx;
        start_d[i] = bus.timestamp;
        age_d[i]   = '0;
        seen_d[i]  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_MON; i++) begin
        state_q[i] <= S_FREE;
        idx_q[i]   <= '0;
        start_q[i] <= '0;
        dexec_q[i] <= '0;
        dend_q[i]  <= '0;
        age_q[i]   <= '0;
      end
      seen_q      <= '0;
      res_valid_q <= 1'b0;
      res_slot_q  <= '0;
      res_dexec_q <= '0;
      res_dend_q  <= '0;
      res_seen_q  <= 1'b0;
      res_to_q    <= 1'b0;
      drop_q      <= '0;
    end else begin
      for (int i = 0; i < NUM_MON; i++) begin
        state_q[i] <= state_d[i];
        idx_q[i]   <= idx_d[i];
        start_q[i] <= start_d[i];
        dexec_q[i] <= dexec_d[i];
        dend_q[i]  <= dend_d[i];
        age_q[i]   <= age_d[i];
      end
      seen_q      <= seen_d;
      res_valid_q <= res_fire;
      if (res_fire) begin
        res_slot_q  <= res_slot_d;
        res_dexec_q <= res_dexec_d;
        res_dend_q  <= res_dend_d;
        res_seen_q  <= res_seen_d;
        res_to_q    <= res_to_d;
      end
      if (drop && (drop_q != '1)) begin
        drop_q <= drop_q + 1'b1;
      end
    end
  end

  assign bus.res_valid     = res_valid_q;
  assign bus.res_slot      = res_slot_q;
  assign bus.res_dur_exec  = res_dexec_q;
  assign bus.res_dur_end   = res_dend_q;
  assign bus.res_exec_seen = res_seen_q;
  assign bus.res_timeout   = res_to_q;
  assign bus.busy_mask     = busy;
  assign bus.drop_cnt      = drop_q;

endmodule

// File: tb/tb_sq_dur_mon_multi.sv
// Scoreboard bench for sq_dur_mon_multi: expected result records are queued
// as retire/timeout stimulus is driven and compared when res_valid fires.
module tb_sq_dur_mon_multi;

  localparam int TO = 20;

  typedef struct packed {
    logic [3:0] slot;
    logic [9:0] dexec;
    logic [9:0] dend;
    logic       seen;
    logic       tmo;
  } rec_t;

  logic       clk;
  logic       reset;
  logic [9:0] cur_ts;
  int         checks;
  int         failures;
  rec_t       exp_q[$];

  sq_dur_mon_multi_if #(.IDX_W(6), .TS_W(10), .CNT_W(8), .NUM_MON(4), .DROP_W(16)) bus ();

  sq_dur_mon_multi #(
    .IDX_W(6), .TS_W(10), .CNT_W(8), .NUM_MON(4), .TIMEOUT(TO), .DROP_W(16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic rec_t mk(input int slot, input int de, input int dn, input bit seen, input bit tmo);
    rec_t r;
    r.slot  = 4'(slot);
    r.dexec = 10'(de);
    r.dend  = 10'(dn);
    r.seen  = seen;
    r.tmo   = tmo;
    return r;
  endfunction

  // Results are sampled mid-cycle and matched in order against the queue.
  always @(negedge clk) begin
    rec_t obs;
    rec_t ex;
    if (bus.res_valid === 1'b1) begin
      obs.slot  = bus.res_slot;
      obs.dexec = bus.res_dur_exec;
      obs.dend  = bus.res_dur_end;
      obs.seen  = bus.res_exec_seen;
      obs.tmo   = bus.res_timeout;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("[TB] FAIL unexpected_result slot=%0d exec=%0d end=%0d seen=%0d to=%0d, expected none",
                 obs.slot, obs.dexec, obs.dend, obs.seen, obs.tmo);
      end else begin
        ex = exp_q.pop_front();
        if (obs !== ex) begin
          failures++;
          $display("[TB] FAIL result got slot=%0d exec=%0d end=%0d seen=%0d to=%0d, expected slot=%0d exec=%0d end=%0d seen=%0d to=%0d",
                   obs.slot, obs.dexec, obs.dend, obs.seen, obs.tmo,
                   ex.slot, ex.dexec, ex.dend, ex.seen, ex.tmo);
        end
      end
    end
  end

  task automatic cyc();
    bus.timestamp = cur_ts;
    @(posedge clk);
    #1;
    cur_ts = cur_ts + 10'd1;
    bus.alloc_valid  = 1'b0;
    bus.exec_valid   = 1'b0;
    bus.retire_valid = 1'b0;
    bus.flush        = 1'b0;
    bus.counter_in   = 8'd1;
  endtask

  task automatic do_alloc(input int idx);
    bus.alloc_valid = 1'b1;
    bus.alloc_idx   = 6'(idx);
    bus.counter_in  = 8'd0;
  endtask

  task automatic do_retire(input int idx);
    bus.retire_valid = 1'b1;
    bus.retire_idx   = 6'(idx);
  endtask

  task automatic do_exec(input int idx);
    bus.exec_valid = 1'b1;
    bus.exec_idx   = 6'(idx);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) cyc();
    checks++;
    if (bus.res_valid !== 1'b0 || bus.res_dur_end !== 10'd0 || bus.res_slot !== 4'd0) begin
      failures++;
      $display("[TB] FAIL reset_res got valid=%0b end=%0d slot=%0d, expected 0 0 0",
               bus.res_valid, bus.res_dur_end, bus.res_slot);
    end
    checks++;
    if (bus.busy_mask !== 4'h0 || bus.drop_cnt !== 16'd0) begin
      failures++;
      $display("[TB] FAIL reset_state got busy=%h drop=%0d, expected 0 0", bus.busy_mask, bus.drop_cnt);
    end
    reset = 1'b1;
    cyc();
  endtask

  task automatic test_single();
    cur_ts = 10'd100;
    do_alloc(5);
    cyc();
    checks++;
    if (bus.busy_mask !== 4'b0001) begin
      failures++;
      $display("[TB] FAIL single_busy got %b, expected 0001", bus.busy_mask);
    end
    repeat (2) cyc();
    do_exec(5);
    cyc();
    repeat (6) cyc();
    exp_q.push_back(mk(0, 3, 10, 1'b1, 1'b0));
    do_retire(5);
    cyc();
    cyc();
    checks++;
    if (exp_q.size() != 0 || bus.busy_mask !== 4'h0) begin
      failures++;
      $display("[TB] FAIL single_done got pending=%0d busy=%h, expected 0 0", exp_q.size(), bus.busy_mask);
    end
    checks++;
    if (bus.res_valid !== 1'b0 || bus.res_dur_end !== 10'd10) begin
      failures++;
      $display("[TB] FAIL single_hold got valid=%0b end=%0d, expected 0 10", bus.res_valid, bus.res_dur_end);
    end
  endtask

  task automatic test_wrap();
    cur_ts = 10'd1020;
    do_alloc(9);
    cyc();
    repeat (7) cyc();
    exp_q.push_back(mk(0, 8, 8, 1'b0, 1'b0));
    do_retire(9);
    cyc();
    cyc();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL wrap_pending got %0d, expected 0", exp_q.size());
    end
  endtask

  task automatic test_capacity();
    cur_ts = 10'd200;
    for (int k = 1; k <= 5; k++) begin
      do_alloc(k);
      cyc();
    end
    checks++;
    if (bus.busy_mask !== 4'hF || bus.drop_cnt !== 16'd1) begin
      failures++;
      $display("[TB] FAIL cap_full got busy=%h drop=%0d, expected F 1", bus.busy_mask, bus.drop_cnt);
    end
    exp_q.push_back(mk(0, 5, 5, 1'b0, 1'b0));
    do_retire(1);
    cyc();
    do_alloc(2);
    cyc();
    checks++;
    if (bus.busy_mask !== 4'hE || bus.drop_cnt !== 16'd2) begin
      failures++;
      $display("[TB] FAIL cap_dup got busy=%h drop=%0d, expected E 2", bus.busy_mask, bus.drop_cnt);
    end
    for (int k = 2; k <= 4; k++) begin
      exp_q.push_back(mk(k - 1, 6, 6, 1'b0, 1'b0));
      do_retire(k);
      cyc();
    end
    cyc();
    checks++;
    if (exp_q.size() != 0 || bus.busy_mask !== 4'h0) begin
      failures++;
      $display("[TB] FAIL cap_done got pending=%0d busy=%h, expected 0 0", exp_q.size(), bus.busy_mask);
    end
  endtask

  task automatic test_timeout();
    cur_ts = 10'd300;
    do_alloc(10);
    cyc();
    repeat (4) cyc();
    do_alloc(11);
    cyc();
    repeat (15) cyc();
    checks++;
    if (bus.busy_mask !== 4'b0011 || bus.res_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL to_armed got busy=%b valid=%0b, expected 0011 0", bus.busy_mask, bus.res_valid);
    end
    exp_q.push_back(mk(1, 16, 16, 1'b0, 1'b0));
    exp_q.push_back(mk(0, TO, TO, 1'b0, 1'b1));
    do_retire(11);
    cyc();
    repeat (2) cyc();
    checks++;
    if (exp_q.size() != 0 || bus.busy_mask !== 4'h0) begin
      failures++;
      $display("[TB] FAIL to_done got pending=%0d busy=%h, expected 0 0", exp_q.size(), bus.busy_mask);
    end
  endtask

  task automatic test_exec_retire_same();
    cur_ts = 10'd40;
    do_alloc(7);
    cyc();
    repeat (9) cyc();
    exp_q.push_back(mk(0, 10, 10, 1'b1, 1'b0));
    do_exec(7);
    do_retire(7);
    do_alloc(7);
    cyc();
    checks++;
    if (bus.busy_mask !== 4'b0010) begin
      failures++;
      $display("[TB] FAIL er_rearm got busy=%b, expected 0010", bus.busy_mask);
    end
    repeat (2) cyc();
    exp_q.push_back(mk(1, 3, 3, 1'b0, 1'b0));
    do_retire(7);
    cyc();
    cyc();
    checks++;
    if (exp_q.size() != 0 || bus.busy_mask !== 4'h0) begin
      failures++;
      $display("[TB] FAIL er_done got pending=%0d busy=%h, expected 0 0", exp_q.size(), bus.busy_mask);
    end
  endtask

  task automatic test_back_to_back();
    cur_ts = 10'd400;
    do_alloc(1);
    cyc();
    do_alloc(2);
    cyc();
    bus.alloc_valid = 1'b1;
    bus.alloc_idx   = 6'd3;
    bus.counter_in  = 8'd5;
    do_exec(1);
    cyc();
    checks++;
    if (bus.busy_mask !== 4'b0011) begin
      failures++;
      $display("[TB] FAIL b2b_busy got %b, expected 0011", bus.busy_mask);
    end
    exp_q.push_back(mk(0, 2, 3, 1'b1, 1'b0));
    do_retire(1);
    cyc();
    exp_q.push_back(mk(1, 3, 3, 1'b0, 1'b0));
    do_retire(2);
    cyc();
    cyc();
    checks++;
    if (exp_q.size() != 0 || bus.busy_mask !== 4'h0) begin
      failures++;
      $display("[TB] FAIL b2b_done got pending=%0d busy=%h, expected 0 0", exp_q.size(), bus.busy_mask);
    end
  endtask

  task automatic test_flush();
    cur_ts = 10'd60;
    for (int k = 20; k <= 22; k++) begin
      do_alloc(k);
      cyc();
    end
    checks++;
    if (bus.busy_mask !== 4'b0111) begin
      failures++;
      $display("[TB] FAIL flush_armed got %b, expected 0111", bus.busy_mask);
    end
    exp_q.push_back(mk(1, 2, 2, 1'b0, 1'b0));
    bus.flush = 1'b1;
    do_retire(21);
    do_alloc(30);
    cyc();
    checks++;
    if (bus.busy_mask !== 4'h0 || bus.drop_cnt !== 16'd2) begin
      failures++;
      $display("[TB] FAIL flush_ret got busy=%h drop=%0d, expected 0 2", bus.busy_mask, bus.drop_cnt);
    end
    for (int k = 40; k <= 42; k++) begin
      do_alloc(k);
      cyc();
    end
    bus.flush = 1'b1;
    cyc();
    checks++;
    if (bus.busy_mask !== 4'h0 || bus.res_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL flush_pure got busy=%h valid=%0b, expected 0 0", bus.busy_mask, bus.res_valid);
    end
    repeat (3) cyc();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL flush_pending got %0d, expected 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    cur_ts = 10'd80;
    do_alloc(50);
    cyc();
    do_exec(50);
    cyc();
    reset = 1'b0;
    do_retire(50);
    cyc();
    checks++;
    if (bus.res_valid !== 1'b0 || bus.res_slot !== 4'd0 || bus.res_dur_exec !== 10'd0 ||
        bus.res_dur_end !== 10'd0 || bus.res_exec_seen !== 1'b0 || bus.res_timeout !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midreset_res got valid=%0b slot=%0d exec=%0d end=%0d seen=%0b to=%0b, expected all 0",
               bus.res_valid, bus.res_slot, bus.res_dur_exec, bus.res_dur_end,
               bus.res_exec_seen, bus.res_timeout);
    end
    checks++;
    if (bus.busy_mask !== 4'h0 || bus.drop_cnt !== 16'd0) begin
      failures++;
      $display("[TB] FAIL midreset_state got busy=%h drop=%0d, expected 0 0", bus.busy_mask, bus.drop_cnt);
    end
    reset = 1'b1;
    repeat (3) cyc();
    checks++;
    if (exp_q.size() != 0 || bus.busy_mask !== 4'h0) begin
      failures++;
      $display("[TB] FAIL midreset_after got pending=%0d busy=%h, expected 0 0", exp_q.size(), bus.busy_mask);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired, simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    checks           = 0;
    failures         = 0;
    cur_ts           = 10'd0;
    reset            = 1'b0;
    bus.counter_in   = 8'd1;
    bus.timestamp    = 10'd0;
    bus.alloc_valid  = 1'b0;
    bus.alloc_idx    = 6'd0;
    bus.exec_valid   = 1'b0;
    bus.exec_idx     = 6'd0;
    bus.retire_valid = 1'b0;
    bus.retire_idx   = 6'd0;
    bus.flush        = 1'b0;
    test_reset();
    test_single();
    test_wrap();
    test_capacity();
    test_timeout();
    test_exec_retire_same();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
